// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Purpose  : Shared constants, types and default coefficients for the
//             symmetric-folded, time-shared FIR MAC (fir_mac_sched).
//  Contents : FIR_TAPS / FIR_NUNIQ / FIR_ACC_W defaults, data widths,
//             DEFAULT_COEFF ROM contents, fir_state_e FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int FIR_TAPS  = 21;  // filter length (odd, symmetric)
  localparam int FIR_NUNIQ = 11;  // unique coefficients, (TAPS+1)/2
  localparam int FIR_ACC_W = 24;  // signed accumulator width

  localparam int SAMPLE_W = 3;    // signed input sample
  localparam int PREADD_W = 4;    // folded pre-add of two samples
  localparam int COEFF_W  = 16;   // signed coefficient
  localparam int PROD_W   = 20;   // PREADD_W + COEFF_W
  localparam int OUT_W    = 16;   // saturated output
  localparam int PTR_W    = 5;    // circular-buffer pointer / offsets
  localparam int K_W      = 4;    // term index and coefficient address

  typedef logic signed [COEFF_W-1:0] coeff_t;

  // c[0] .. c[10]; c[10] is the centre tap.
  localparam coeff_t DEFAULT_COEFF [FIR_NUNIQ] = '{
    16'sh000D, 16'sh0000, 16'sh0013, 16'sh0018, 16'sh0000, 16'sh0025,
    16'sh0030, 16'sh0000, 16'sh0066, 16'sh00CE, 16'sh01F4
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_e;

endpackage
`default_nettype wire

// File: rtl/fir_mac_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sched_if
//  Purpose  : Sample/result bus of fir_mac_sched.
//  Signals  : iEnSample_600kHz (sample strobe), iFirIn (3b signed sample),
//             oFirOut (16b signed result), oFirValid (result pulse),
//             oBusy (computation in progress), oOverrun (sticky drop flag);
//             iCoeffWr / iCoeffAddr / iCoeffData only when FIR_COEFF_WR_EN
//             is defined.
//  Modports : master (sample source / result sink), slave (the filter).
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_sched_if;
  import fir_pkg::*;

  logic                       iEnSample_600kHz;
  logic signed [SAMPLE_W-1:0] iFirIn;
  logic signed [OUT_W-1:0]    oFirOut;
  logic                       oFirValid;
  logic                       oBusy;
  logic                       oOverrun;
`ifdef FIR_COEFF_WR_EN
  logic                       iCoeffWr;
  logic [K_W-1:0]             iCoeffAddr;
  coeff_t                     iCoeffData;

  modport master (
    output iEnSample_600kHz, iFirIn, iCoeffWr, iCoeffAddr, iCoeffData,
    input  oFirOut, oFirValid, oBusy, oOverrun
  );
  modport slave (
    input  iEnSample_600kHz, iFirIn, iCoeffWr, iCoeffAddr, iCoeffData,
    output oFirOut, oFirValid, oBusy, oOverrun
  );
`else
  modport master (
    output iEnSample_600kHz, iFirIn,
    input  oFirOut, oFirValid, oBusy, oOverrun
  );
  modport slave (
    input  iEnSample_600kHz, iFirIn,
    output oFirOut, oFirValid, oBusy, oOverrun
  );
`endif

endinterface
`default_nettype wire

// File: rtl/fir_sample_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sample_buf
//  Purpose  : TAPS-entry circular history of signed samples with one write
//             port and two combinational read ports addressed by offset
//             from the newest sample (offset 0 = newest).
//  Ports    : clk, rst (sync, active-high), wr_en, wr_data,
//             off_a / off_b (newest-relative offsets), rd_a / rd_b.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_sample_buf
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic signed [SAMPLE_W-1:0] wr_data,
  input  logic [PTR_W-1:0]           off_a,
  input  logic [PTR_W-1:0]           off_b,
  output logic signed [SAMPLE_W-1:0] rd_a,
  output logic signed [SAMPLE_W-1:0] rd_b
);

  logic signed [SAMPLE_W-1:0] mem [TAPS];
  logic [PTR_W-1:0]           wr_ptr;

  // wr_ptr points at the slot the next sample will land in, so the newest
  // stored sample lives at wr_ptr-1 (mod TAPS).
  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base,
                                            input logic [PTR_W-1:0] off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(TAPS-1) - {1'b0, off};
    if (sum >= (PTR_W+1)'(TAPS)) sum = sum - (PTR_W+1)'(TAPS);
    return sum[PTR_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= (wr_ptr == PTR_W'(TAPS-1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  assign rd_a = mem[slot(wr_ptr, off_a)];
  assign rd_b = mem[slot(wr_ptr, off_b)];

endmodule
`default_nettype wire

// File: rtl/fir_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sched
//  Purpose  : Symmetric FIR filter that time-shares one 4x16 signed
//             multiplier: each strobe stores a sample, then NUNIQ folded
//             terms (x[n-k] + x[n-(TAPS-1)+k]) * c[k] are accumulated one per
//             cycle, the sum is saturated to 16 bits and presented with a
//             one-cycle valid pulse.
//  Ports    : iClk_12MHz, iRst (sync, active-high),
//             bus : fir_mac_sched_if.slave (strobe, sample, result, valid,
//                   busy, overrun; coefficient write port when enabled).
//  Config   : FIR_COEFF_WR_EN - adds a writable shadow coefficient bank
//             that is copied to the active bank when a computation starts;
//             undefined, coefficients are a constant ROM.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int TAPS  = FIR_TAPS,
  parameter int NUNIQ = FIR_NUNIQ,
  parameter int ACC_W = FIR_ACC_W
) (
  input  logic            iClk_12MHz,
  input  logic            iRst,
  fir_mac_sched_if.slave  bus
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W-1)));

  fir_state_e                 state;
  fir_state_e                 next_state;
  logic [K_W-1:0]             k;
  logic signed [ACC_W-1:0]    acc;
  logic signed [OUT_W-1:0]    fir_out;
  logic                       fir_valid;
  logic                       overrun;

  logic                       strobe;
  logic                       last_term;
  logic                       start;
  logic                       mac_en;
  logic                       done_en;
  logic                       drop;
  logic                       busy;

  logic [PTR_W-1:0]           off_a;
  logic [PTR_W-1:0]           off_b;
  logic signed [SAMPLE_W-1:0] rd_a;
  logic signed [SAMPLE_W-1:0] rd_b;
  logic signed [PREADD_W-1:0] pre_add;
  coeff_t                     coef_k;
  logic signed [PROD_W-1:0]   prod;
  logic signed [OUT_W-1:0]    sat_val;

  coeff_t                     coeff_active [NUNIQ];

  assign strobe    = bus.iEnSample_600kHz;
  assign last_term = (k == K_W'(NUNIQ-1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge iClk_12MHz) begin
    if (iRst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (strobe)    next_state = ST_MAC;
      ST_MAC:  if (last_term) next_state = ST_DONE;
      ST_DONE:                next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Any strobe outside IDLE is a drop; only IDLE accepts a sample.
  always_comb begin
    start   = 1'b0;
    mac_en  = 1'b0;
    done_en = 1'b0;
    drop    = strobe;
    busy    = 1'b1;
    case (state)
      ST_IDLE: begin
        busy  = 1'b0;
        drop  = 1'b0;
        start = strobe;
      end
      ST_MAC:  mac_en  = 1'b1;
      ST_DONE: done_en = 1'b1;
      default: ;
    endcase
  end

  // ---------------- sample history ----------------
  assign off_a = PTR_W'(k);
  assign off_b = PTR_W'(TAPS-1) - PTR_W'(k);

  fir_sample_buf #(
    .TAPS (TAPS)
  ) u_buf (
    .clk     (iClk_12MHz),
    .rst     (iRst),
    .wr_en   (start),
    .wr_data (bus.iFirIn),
    .off_a   (off_a),
    .off_b   (off_b),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  // ---------------- coefficients ----------------
`ifdef FIR_COEFF_WR_EN
  coeff_t coeff_shadow [NUNIQ];

  // The active bank only changes on the start edge, so a write that lands
  // on that same edge is seen by the following sample, not this one.
  always_ff @(posedge iClk_12MHz) begin
    if (iRst) begin
      for (int i = 0; i < NUNIQ; i++) begin
        coeff_shadow[i] <= DEFAULT_COEFF[i];
        coeff_active[i] <= DEFAULT_COEFF[i];
      end
    end else begin
      if (bus.iCoeffWr && (bus.iCoeffAddr <= K_W'(NUNIQ-1)))
        coeff_shadow[bus.iCoeffAddr] <= bus.iCoeffData;
      if (start) begin
        for (int i = 0; i < NUNIQ; i++) coeff_active[i] <= coeff_shadow[i];
      end
    end
  end
`else
  for (genvar i = 0; i < NUNIQ; i++) begin : g_coeff_rom
    assign coeff_active[i] = DEFAULT_COEFF[i];
  end
`endif

  // ---------------- folded multiply ----------------
  // The centre tap has no mirror partner (both read ports see the same
  // sample), so it is taken alone.
  always_comb begin
    pre_add = PREADD_W'(rd_a);
    if (!last_term) pre_add = PREADD_W'(rd_a) + PREADD_W'(rd_b);
  end

  assign coef_k = coeff_active[k];
  assign prod   = PROD_W'(pre_add) * PROD_W'(coef_k);

  always_comb begin
    sat_val = acc[OUT_W-1:0];
    if (acc > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
    else if (acc < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge iClk_12MHz) begin
    if (iRst) begin
      k         <= '0;
      acc       <= '0;
      fir_out   <= '0;
      fir_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      fir_valid <= 1'b0;
      if (drop) overrun <= 1'b1;
      if (start) begin
        acc <= '0;
        k   <= '0;
      end
      if (mac_en) begin
        acc <= acc + ACC_W'(prod);
        k   <= last_term ? '0 : k + 1'b1;
      end
      if (done_en) begin
        fir_out   <= sat_val;
        fir_valid <= 1'b1;
      end
    end
  end

  assign bus.oFirOut   = fir_out;
  assign bus.oFirValid = fir_valid;
  assign bus.oBusy     = busy;
  assign bus.oOverrun  = overrun;

endmodule
`default_nettype wire

// File: doc/fir_mac_sched.md
FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

Interface
REQ-001 Parameter TAPS, default 21; filter length, odd, symmetric coefficients.
REQ-002 Parameter NUNIQ, default 11; unique coefficients, (TAPS+1)/2.
REQ-003 Parameter ACC_W, default 24; accumulator width, signed.
REQ-004 Port iClk_12MHz  in  1; single clock, all logic on its rising edge.
REQ-005 Port iRst  in  1; reset, synchronous, active-high.
REQ-006 Port iEnSample_600kHz  in  1; one-cycle sample strobe.
REQ-007 Port iFirIn  in  3; signed input sample.
REQ-008 Port oFirOut  out  16; signed filter result, registered.
REQ-009 Port oFirValid  out  1; one-cycle pulse when oFirOut updates.
REQ-010 Port oBusy  out  1; high whenever state is not IDLE.
REQ-011 Port oOverrun  out  1; sticky flag, set when a strobe is dropped.
REQ-012 Ports iCoeffWr (1), iCoeffAddr (4), iCoeffData (16, signed), all inputs; exist only under FIR_COEFF_WR_EN.

Function
REQ-013 The block SHALL time-share one 4x16 signed multiplier across all taps, using symmetric folding: term k = (x[n-k] + x[n-20+k]) * c[k] for k=0..9, and term 10 = x[n-10] * c[10].
REQ-014 The block SHALL hold the sample history in a 21-entry circular buffer of 3-bit signed values, with a 5-bit write pointer that wraps 20->0.
REQ-015 The FSM SHALL have states IDLE, MAC and DONE; on reset it SHALL enter IDLE.
REQ-016 IDLE -> MAC on a strobe: at that edge, write iFirIn at the pointer, advance the pointer, clear the accumulator, set k=0.
REQ-017 MAC SHALL add one folded term per cycle for exactly NUNIQ cycles (k=0..10), then go to DONE.
REQ-018 DONE SHALL saturate the accumulator to 16-bit signed range (0x7FFF / 0x8000), register it to oFirOut, pulse oFirValid, then return to IDLE.
REQ-019 Latency: oFirValid SHALL be high exactly 13 cycles after the cycle in which the strobe was sampled high, i.e. 1 edge IDLE->MAC, 11 MAC edges, 1 DONE edge.
REQ-020 A strobe seen while not in IDLE SHALL be dropped without touching the buffer, and SHALL set oOverrun.
REQ-021 The pre-add SHALL be 4-bit signed; the product SHALL be 20-bit signed; the accumulation SHALL be ACC_W-bit signed with no intermediate truncation.
REQ-022 oFirOut SHALL hold its value between oFirValid pulses.
REQ-023 Default coefficients c[0..10] (hex) SHALL be 000D, 0000, 0013, 0018, 0000, 0025, 0030, 0000, 0066, 00CE, 01F4.

Reset
REQ-024 When iRst is high at an edge, the block SHALL: zero all buffer entries, the pointer, the accumulator and k; set oFirOut=0, oFirValid=0, oOverrun=0; set state to IDLE.
REQ-025 Reset during MAC or DONE SHALL abort the computation, and no oFirValid SHALL follow.
REQ-026 A strobe coincident with iRst SHALL be ignored.

Configuration
REQ-027 Macro FIR_COEFF_WR_EN defined: the block SHALL have a writable shadow coefficient bank, loaded with iCoeffData at iCoeffAddr when iCoeffWr is high; addresses above 10 are ignored.
REQ-028 With FIR_COEFF_WR_EN, the shadow bank SHALL copy to the active bank only on the IDLE->MAC edge, so one computation always uses a single consistent set.
REQ-029 A write coincident with the swap edge SHALL go to the shadow bank and take effect on the next sample.
REQ-030 With FIR_COEFF_WR_EN, reset SHALL restore both banks to the defaults.
REQ-031 Macro undefined: coefficients SHALL be a constant ROM, and the write ports SHALL be absent.

Structure
REQ-032 Shared package fir_pkg SHALL hold TAPS, NUNIQ, the data widths, the default coefficient array and the FSM state enum.
REQ-033 The circular buffer SHALL be sub-module fir_sample_buf, with one write port and two combinational read ports (newest-relative offsets k and 20-k).

Verification
REQ-034 Impulse: input 1, then 20 zeros -> 21 outputs 000D, 0000, 0013, 0018, 0000, 0025, 0030, 0000, 0066, 00CE, 01F4, then the same sequence mirrored.
REQ-035 DC: constant -4 for 25 samples -> output from the 21st sample onward is 0xEA28 (-5592); constant +3 -> 0x1062.
REQ-036 Latency/overrun: two strobes 5 cycles apart -> one oFirValid, 13 cycles after the first strobe; oOverrun=1; second sample absent from the history.
REQ-037 Reset mid-MAC: iRst at MAC cycle 6 -> no oFirValid; next impulse reproduces the REQ-034 sequence from a zero history.
REQ-038 FIR_COEFF_WR_EN: write addr 10 = 0x7FFF while busy; the current output is unchanged; a following impulse of +3 gives a saturated 0x7FFF center output; a write to addr 12 has no effect.
